dpsk_symbol_mod: RTL and testbench
==================================

// Module: dpsk_symbol_mod
// PURPOSE
//  DPSK modulator stage that sits directly downstream of the DDS carrier generator (dds_st).
//  Takes serial data bits over a valid/ready handshake and differentially encodes them
//  (d_k = d_{k-1} XOR b_k).
//  Outputs the sine carrier as-is or negated (0/180 deg) for each symbol of SPS carrier samples.
//  Output feeds the DAC/shaping path.
// PARAMETERS
//  MPR   10  carrier/output sample width (two's complement); matches DDS mpr
//  SPS   16  carrier samples per symbol, legal range 2..2^CNTW
//  CNTW  5   sample-counter width
// PORTS
//  clk        in   1    system clock
//  reset      in   1    asynchronous, active-high reset
//  clken      in   1    global clock enable; no state changes when 0
//  tx_en      in   1    1 = transmit; 0 = stop at next symbol boundary
//  fsin_i     in   MPR  DDS sine sample
//  car_valid  in   1    DDS out_valid
//  bit_i      in   1    data bit (1 = phase flip)
//  bit_valid  in   1    bit_i valid
//  bit_ready  out  1    block accepts bit_i this cycle
//  mod_o      out  MPR  modulated sample, registered
//  mod_valid  out  1    mod_o valid
//  sym_start  out  1    high with the first mod_o sample of each symbol
//  underrun   out  1    sticky; set when a symbol starts with no buffered bit
// BEHAVIOUR
//  - Strobe: stb = clken & car_valid. Counter, FSM, encoder and output advance only on stb.
//    The bit buffer also loads on clken alone.
//  - Reset: every output and all state go to 0; FSM = IDLE; buffered bit discarded.
//    Reset may assert mid-symbol and takes effect immediately.
//  - Bit buffer (1 entry): bit_ready = clken & (!buf_full | consume).
//    A transfer occurs when bit_valid & bit_ready. Load and consume in the same cycle is allowed.
//  - FSM IDLE: mod_o = 0, mod_valid = 0, diff state d = 0, cnt = 0.
//    Go to RUN on stb & tx_en & buf_full: consume the bit, set d = b, cnt = 0, sym_start = 1.
//  - FSM RUN, each stb: cnt increments. On cnt == SPS-1, cnt wraps to 0 and a symbol boundary occurs:
//      tx_en = 0        -> go to IDLE; the last sample of the current symbol is still output.
//      buffer full      -> consume the bit; d <= d ^ b.
//      buffer empty     -> insert bit 0 (d unchanged); set underrun.
//  - Output: mod_o is registered 1 clk after stb.
//      mod_o = fsin_i when d = 0.
//      mod_o = -fsin_i when d = 1, saturated: -(-2^(MPR-1)) gives 2^(MPR-1)-1.
//    mod_valid = stb registered (RUN only). sym_start coincides with the mod_valid of sample cnt = 0.
//  - car_valid falling mid-symbol freezes cnt/d/mod_o; mod_valid = 0 until the next stb.
//  - underrun is cleared only by reset.
// CONFIGURATION
//  DPSK_QOUT_EN defined:
//    - adds ports fcos_i (in, MPR) and modq_o (out, MPR).
//    - modq_o is fcos_i with the same d/negation/saturation and the same latency as mod_o.
//    - modq_o resets to 0.
//  DPSK_QOUT_EN undefined:
//    - those ports are absent; behaviour otherwise identical.
// TESTING
//  T1 Reset:
//     assert reset mid-RUN -> mod_o = 0, mod_valid = 0, bit_ready = 0 while reset is high;
//     underrun = 0 after release.
//  T2 Bits 1,0,1,1 with SPS = 16, fsin_i = 100 constant, car_valid = 1:
//     mod_o = -100 x16, -100 x16, 100 x16, -100 x16;
//     sym_start at samples 0, 16, 32, 48.
//  T3 Saturation:
//     fsin_i = -512 with d = 1 -> mod_o = 511;
//     fsin_i = 511 -> mod_o = -511.
//  T4 Underrun:
//     supply 1 bit, then hold bit_valid = 0 -> 2nd symbol keeps the phase and underrun = 1
//     from the 2nd sym_start onward.
//  T5 Flow control:
//     gate car_valid 50% and clken randomly -> one symbol = exactly SPS mod_valid pulses;
//     no bit is lost or duplicated (scoreboard 1000 random bits).
//  T6 tx_en dropped mid-symbol:
//     the symbol completes all 16 samples, then IDLE with mod_valid = 0;
//     re-enable restarts with d = b_first.

Source files
------------

// File: rtl/dpsk_symbol_mod.sv
// DPSK symbol modulator: differentially encodes handshaked data bits and flips the DDS
// sine carrier by 0/180 deg per SPS-sample symbol. Optional I/Q output: DPSK_QOUT_EN.
module dpsk_symbol_mod #(
    parameter int MPR  = 10,
    parameter int SPS  = 16,
    parameter int CNTW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic           tx_en,
    input  logic [MPR-1:0] fsin_i,
    input  logic           car_valid,
    input  logic           bit_i,
    input  logic           bit_valid,
    output logic           bit_ready,
    output logic [MPR-1:0] mod_o,
    output logic           mod_valid,
    output logic           sym_start,
`ifdef DPSK_QOUT_EN
    input  logic [MPR-1:0] fcos_i,
    output logic [MPR-1:0] modq_o,
`endif
    output logic           underrun
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SPS - 1);
    localparam logic [MPR-1:0]  S_MIN    = {1'b1, {(MPR-1){1'b0}}};
    localparam logic [MPR-1:0]  S_MAX    = {1'b0, {(MPR-1){1'b1}}};

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            d_q, d_d;
    logic            starved_q, starved_d;
    logic            buf_full_q, buf_bit_q;
    logic            stb, consume, run_stb;

    // Negation saturates the single asymmetric code instead of wrapping back to itself.
    function automatic logic [MPR-1:0] apply_phase(input logic [MPR-1:0] x, input logic neg);
        if (!neg)
            return x;
        else if (x == S_MIN)
            return S_MAX;
        else
            return ~x + 1'b1;
    endfunction

    assign stb       = clken & car_valid;
    assign run_stb   = stb & (state_q == RUN);
    assign bit_ready = clken & ~reset & (~buf_full_q | consume);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        starved_d = starved_q;
        consume   = 1'b0;
        if (stb) begin
            case (state_q)
                IDLE: begin
                    if (tx_en && buf_full_q) begin
                        state_d   = RUN;
                        consume   = 1'b1;
                        d_d       = buf_bit_q;
                        cnt_d     = '0;
                        starved_d = 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!tx_en) begin
                            state_d   = IDLE;
                            d_d       = 1'b0;
                            starved_d = 1'b0;
                        end else if (buf_full_q) begin
                            consume   = 1'b1;
                            d_d       = d_q ^ buf_bit_q;
                            starved_d = 1'b0;
                        end else begin
                            starved_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_q        <= 1'b0;
            starved_q  <= 1'b0;
            buf_full_q <= 1'b0;
            buf_bit_q  <= 1'b0;
            mod_o      <= '0;
            mod_valid  <= 1'b0;
            sym_start  <= 1'b0;
            underrun   <= 1'b0;
`ifdef DPSK_QOUT_EN
            modq_o     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            starved_q <= starved_d;
            mod_valid <= run_stb;
            sym_start <= run_stb && (cnt_q == '0);
            // Underrun is flagged with the first sample of the symbol that had no bit.
            if (run_stb && (cnt_q == '0) && starved_q)
                underrun <= 1'b1;
            if (stb) begin
                mod_o <= (state_q == RUN) ? apply_phase(fsin_i, d_q) : '0;
`ifdef DPSK_QOUT_EN
                modq_o <= (state_q == RUN) ? apply_phase(fcos_i, d_q) : '0;
`endif
            end
            if (bit_valid && bit_ready) begin
                buf_full_q <= 1'b1;
                buf_bit_q  <= bit_i;
            end else if (consume) begin
                buf_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dpsk_symbol_mod.sv
// Self-checking bench for dpsk_symbol_mod: randomized stimulus against a sample-stream
// reference model (bit queue, running XOR phase, saturated negation).
module tb_dpsk_symbol_mod;

    localparam int MPR  = 10;
    localparam int SPS  = 16;
    localparam int CNTW = 5;
    localparam int MAXV = (1 << (MPR - 1)) - 1;
    localparam int MINV = -(1 << (MPR - 1));

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           clken = 1'b0;
    logic           tx_en = 1'b0;
    logic           car_valid = 1'b0;
    logic           bit_i = 1'b0;
    logic           bit_valid = 1'b0;
    logic [MPR-1:0] fsin_i = '0;
    logic           bit_ready, mod_valid, sym_start, underrun;
    logic [MPR-1:0] mod_o;
`ifdef DPSK_QOUT_EN
    logic [MPR-1:0] fcos_i = '0;
    logic [MPR-1:0] modq_o;
`endif

    dpsk_symbol_mod #(.MPR(MPR), .SPS(SPS), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .tx_en     (tx_en),
        .fsin_i    (fsin_i),
        .car_valid (car_valid),
        .bit_i     (bit_i),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .mod_o     (mod_o),
        .mod_valid (mod_valid),
        .sym_start (sym_start),
`ifdef DPSK_QOUT_EN
        .fcos_i    (fcos_i),
        .modq_o    (modq_o),
`endif
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int src_q[$];
    int acc_q[$];
    int n = 0;
    int phase = 0;
    int exp_und = 0;
    int prev_fs = 0;
    int prev_fc = 0;
    bit prev_stb = 1'b0;
    bit pend_v = 1'b0;
    int pend_b = 0;
    int mv_count = 0;

    // Stimulus knobs
    int ce_pct = 100;
    int cv_pct = 100;
    int fs_mode = 0;
    int fs_const = 100;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int neg_sat(input int x);
        int y;
        y = -x;
        return (y > MAXV) ? MAXV : y;
    endfunction

    function automatic int sx(input logic [MPR-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic monitor();
        int exp_o;
        if (!prev_stb) check("mv_hold", int'(mod_valid), 0);
        if (mod_valid) begin
            mv_count++;
            if (n % SPS == 0) begin
                if (acc_q.size() > 0) phase = phase ^ acc_q.pop_front();
                else exp_und = 1;
            end
            check("sym_start", int'(sym_start), int'(n % SPS == 0));
            exp_o = (phase != 0) ? neg_sat(prev_fs) : prev_fs;
            check("mod_o", sx(mod_o), exp_o);
`ifdef DPSK_QOUT_EN
            check("modq_o", sx(modq_o), (phase != 0) ? neg_sat(prev_fc) : prev_fc);
`endif
            n++;
        end else begin
            check("sym_start_idle", int'(sym_start), 0);
        end
        check("underrun", int'(underrun), exp_und);
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic cycle();
        logic ce, cv;
        monitor();
        if (pend_v) begin
            acc_q.push_back(pend_b);
            pend_v = 1'b0;
        end
        ce = ($urandom_range(99) < ce_pct);
        cv = ($urandom_range(99) < cv_pct);
        clken = ce;
        car_valid = cv;
        case (fs_mode)
            0: fsin_i = MPR'(fs_const);
            1: fsin_i = MPR'($urandom);
            default: fsin_i = ($urandom_range(1) == 1) ? MPR'(MINV) : MPR'(MAXV);
        endcase
`ifdef DPSK_QOUT_EN
        fcos_i = ($urandom_range(3) == 0) ? MPR'(MINV) : MPR'($urandom);
`endif
        bit_valid = (src_q.size() > 0);
        bit_i = 1'b0;
        if (bit_valid) bit_i = (src_q[0] != 0);
        #1;
        if (bit_valid && bit_ready) begin
            pend_v = 1'b1;
            pend_b = int'(bit_i);
            void'(src_q.pop_front());
        end
        prev_fs = sx(fsin_i);
`ifdef DPSK_QOUT_EN
        prev_fc = sx(fcos_i);
`endif
        prev_stb = ce & cv;
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n < target && k < budget) begin
            cycle();
            k++;
        end
        check(tag, n, target);
    endtask

    task automatic go_idle(input string tag);
        tx_en = 1'b0;
        repeat (400) cycle();
        check({tag, "_symlen"}, n % SPS, 0);
        mv_count = 0;
        repeat (60) cycle();
        check({tag, "_idle"}, mv_count, 0);
        n = 0;
        phase = 0;
    endtask

    task automatic load_random_bits(input int count);
        for (int i = 0; i < count; i++) src_q.push_back(int'($urandom_range(1)));
    endtask

    initial begin
        // Reset state
        clken = 1'b1;
        bit_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mod_o", sx(mod_o), 0);
        check("rst_mod_valid", int'(mod_valid), 0);
        check("rst_sym_start", int'(sym_start), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_bit_ready", int'(bit_ready), 0);
        bit_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // T2: bits 1,0,1,1 on a constant carrier of 100
        src_q = '{1, 0, 1, 1};
        tx_en = 1'b1;
        run_until(3 * SPS + 2, 300, "t2_run");
        go_idle("t2");
        check("t2_bits_left", acc_q.size() + src_q.size(), 0);

        // T3: saturation at both rails with d = 1
        fs_mode = 2;
        src_q = '{1, 0};
        tx_en = 1'b1;
        run_until(SPS + 4, 300, "t3_run");
        go_idle("t3");

        // T4: one bit only, second symbol is an underrun
        fs_mode = 1;
        src_q = '{1};
        tx_en = 1'b1;
        run_until(SPS + 4, 300, "t4_run");
        check("t4_underrun", int'(underrun), 1);
        go_idle("t4");

        // T6: tx_en dropped mid-symbol, then restarted
        ce_pct = 80;
        cv_pct = 60;
        load_random_bits(6);
        tx_en = 1'b1;
        run_until(SPS + 5, 600, "t6_run");
        go_idle("t6");
        tx_en = 1'b1;
        run_until(SPS + 2, 600, "t6_restart");
        go_idle("t6b");

        // T1: reset mid-run
        load_random_bits(4);
        tx_en = 1'b1;
        run_until(SPS + 5, 600, "t1_run");
        reset = 1'b1;
        clken = 1'b1;
        bit_valid = 1'b1;
        #1;
        check("t1_mod_o", sx(mod_o), 0);
        check("t1_mod_valid", int'(mod_valid), 0);
        check("t1_bit_ready", int'(bit_ready), 0);
        @(negedge clk);
        check("t1_mod_o_hold", sx(mod_o), 0);
        check("t1_mod_valid_hold", int'(mod_valid), 0);
        check("t1_bit_ready_hold", int'(bit_ready), 0);
        acc_q.delete();
        src_q.delete();
        pend_v = 1'b0;
        n = 0;
        phase = 0;
        exp_und = 0;
        prev_stb = 1'b0;
        tx_en = 1'b0;
        bit_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("t1_underrun", int'(underrun), 0);

        // T5: random clken and 50% carrier gating over 1000 random bits
        ce_pct = 75;
        cv_pct = 50;
        load_random_bits(1000);
        tx_en = 1'b1;
        run_until(1000 * SPS - 8, 60000, "t5_run");
        go_idle("t5");
        check("t5_bits_left", acc_q.size() + src_q.size() + int'(pend_v), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
